nubus_slot_cpld: RTL and testbench
==================================

NUBUS_SLOT_CPLD -- requirements
Module: nubus_slot_cpld

Interface
REQ-001 Parameter ARB_SETTLE, default 2: consecutive clocks that bus ARB lines must equal own ID before grant.
REQ-002 One clock, fpga_to_cpld_clk (input, 1), rising-edge, all state.
REQ-003 Reset, fpga_to_cpld_signal (input, 1): asynchronous, active-high.
REQ-004 fpga_to_cpld_signal_2 (input, 1): reserved, ignored.
REQ-005 nubus_oe, tmoen, nubus_master_dir (input, 1 each): FPGA transceiver enable, FPGA drives TM/ACK, FPGA is bus master.
REQ-006 id_n_5v (input, 4), reset_n_5v, clk_n_5v, clk2x_n_5v (input, 1): 5 V slot ID, reset, clocks.
REQ-007 id_n_3v3 (output, 4), reset_n_3v3, clk_n_3v3, clk2x_n_3v3 (output, 1): 3.3 V copies.
REQ-008 arb (input, 1), arb_n_5v (input, 4), arb_o_n (output, 4), grant (output, 1): arbitration request, bus ARB lines, open-collector driver enables (low = pull line low), bus won.
REQ-009 tm0/tm1/tm2/start/ack: *_n_5v (input, 1), *_n_3v3 (inout, 1), *_o_n (output, 1) driver data.
REQ-010 tmx_oe_n, tm2_oe_n, start_oe_n, ack_oe_n (output, 1): active-low driver enables.
REQ-011 rqst_n_3v3 (input, 1), rqst_n_5v (input, 1), rqst_o_n (output, 1): FPGA request, bus RQST, driver enable.

Function
REQ-012 id/reset/clk/clk2x 3v3 outputs SHALL equal their 5 V inputs combinationally.
REQ-013 tmoen=1: tmx_oe_n=0, ack_oe_n=0, tm0_o_n=tm0_n_3v3, tm1_o_n=tm1_n_3v3, ack_o_n=ack_n_3v3, those 3v3 pins tri-stated.
REQ-014 tmoen=0: tmx_oe_n=1, ack_oe_n=1, tm0/tm1/ack_n_3v3 driven from 5 V inputs.
REQ-015 Start: nubus_master_dir=1 -> start_oe_n=0, start_o_n=start_n_3v3, 3v3 pin tri-stated; else start_oe_n=1, start_n_3v3=start_n_5v.
REQ-016 rqst_o_n SHALL equal rqst_n_3v3 (combinational); rqst_n_5v accepted, unused.
REQ-017 Arbitration, id=~id_n_5v, a=~arb_n_5v, r=(state!=IDLE): drive[3]=r&id[3]; drive[i]=r&id[i]&AND over j>i of (id[j]|~a[j]); arb_o_n=~drive.
REQ-018 FSM IDLE->ARB when arb=1; ARB->WON after ARB_SETTLE consecutive clocks with a==id; any mismatch restarts count.
REQ-019 grant=1 only in WON; WON->IDLE and ARB->IDLE when arb=0, next clock.
REQ-020 reset_n_5v=0 (synchronous, sampled) SHALL force IDLE, grant=0, arb_o_n=4'hF.
REQ-021 Counter SHALL saturate at ARB_SETTLE, never wrap.

Reset
REQ-022 On reset: state IDLE, counter 0, grant=0, arb_o_n=4'hF; combinational pass-through paths unaffected.
REQ-023 Reset asserted mid-arbitration SHALL release ARB lines within the same cycle (asynchronous).

Configuration
REQ-024 Macro NUBUS_TM2_EN defined: tm2 follows REQ-013/014 (tm2_oe_n=tmx_oe_n, tm2_o_n=tm2_n_3v3, else tm2_n_3v3=tm2_n_5v).
REQ-025 Without NUBUS_TM2_EN: tm2_oe_n=1, tm2_o_n=1, tm2_n_3v3 tri-stated.

Structure
REQ-026 Package nubus_cpld_pkg SHALL hold ID width constant (4) and FSM state enum {IDLE, ARB, WON}.
REQ-027 Arbitration logic and FSM SHALL reside in one sub-module nubus_cpld_arb; pass-through logic at top.

Verification
REQ-028 id_n_5v=4'hF, clk_n_5v toggling -> id_n_3v3=4'hF, clk_n_3v3 tracks with zero cycles.
REQ-029 tmoen=0, tm1/tm0_n_5v=2'b01 -> tm1/tm0_n_3v3=2'b01, tmx_oe_n=1; tmoen=1, ack_n_3v3=0 -> ack_oe_n=0, ack_o_n=0.
REQ-030 ID 5 (id_n_5v=4'hA), arb=1, arb_n_5v=4'hA -> grant=1 exactly 3 clocks after arb (IDLE->ARB, +2 settle).
REQ-031 ID 5, arb=1, bus shows ID 9 (arb_n_5v=4'h6) -> arb_o_n=4'hF, grant stays 0.
REQ-032 Granted, reset pulse or reset_n_5v=0 -> grant=0, arb_o_n=4'hF; arb=0 -> IDLE next clock.
REQ-033 Build without NUBUS_TM2_EN, tmoen=1 -> tm2_oe_n=1.

Source files
------------

// File: rtl/nubus_cpld_pkg.sv
// Shared constants and arbitration FSM state encoding for the NuBus slot CPLD.
// Latency: n/a (types only). Backpressure: n/a.
// Build option: NUBUS_TM2_EN (consumed by nubus_slot_cpld).
package nubus_cpld_pkg;

    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        WON  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/nubus_cpld_arb.sv
// NuBus distributed arbitration: drives open-collector ARB lines and tracks win/loss.
// Latency: ARB entered 1 clock after arb, grant after ARB_SETTLE further matching clocks.
// Backpressure: none; the request is held by the FPGA, and dropping arb returns to IDLE next clock.
module nubus_cpld_arb
    import nubus_cpld_pkg::*;
#(
    parameter int ARB_SETTLE = 2
) (
    input  logic            fpga_to_cpld_clk,
    input  logic            fpga_to_cpld_signal,
    input  logic            reset_n_5v,
    input  logic            arb,
    input  logic [ID_W-1:0] id_n_5v,
    input  logic [ID_W-1:0] arb_n_5v,
    output logic [ID_W-1:0] arb_o_n,
    output logic            grant
);

    localparam int CW = (ARB_SETTLE < 1) ? 1 : $clog2(ARB_SETTLE + 1);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW:0]     cnt_inc;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] a;
    logic            match;

    assign id      = ~id_n_5v;
    assign a       = ~arb_n_5v;
    assign match   = (a == id);
    assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge fpga_to_cpld_clk or posedge fpga_to_cpld_signal) begin
        if (fpga_to_cpld_signal) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: if (arb) state_nxt = ARB;
            ARB: begin
                if (!arb) begin
                    state_nxt = IDLE;
                end else if (match) begin
                    // Count saturates; any mismatching clock falls through and clears it.
                    cnt_nxt = (cnt_inc > (CW+1)'(ARB_SETTLE)) ? cnt : cnt_inc[CW-1:0];
                    if (cnt_inc >= (CW+1)'(ARB_SETTLE)) state_nxt = WON;
                end
            end
            WON: if (!arb) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!reset_n_5v) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    // Bit i is driven only while every higher-priority bit either matches our ID or is not asserted.
    always_comb begin
        logic            r;
        logic            ok;
        logic [ID_W-1:0] drive;
        r     = (state != IDLE);
        ok    = 1'b1;
        drive = '0;
        for (int i = ID_W - 1; i >= 0; i--) begin
            drive[i] = r & id[i] & ok;
            ok       = ok & (id[i] | ~a[i]);
        end
        arb_o_n = ~drive;
        grant   = (state == WON);
    end

endmodule

// File: rtl/nubus_slot_cpld.sv
// NuBus slot CPLD: 5 V <-> 3.3 V level-shift steering plus slot arbitration. Build option NUBUS_TM2_EN.
// Latency: pass-through paths are combinational; arbitration per nubus_cpld_arb.
// Backpressure: none; direction/enables follow tmoen and nubus_master_dir directly.
module nubus_slot_cpld
    import nubus_cpld_pkg::*;
#(
    parameter int ARB_SETTLE = 2
) (
    input  logic            fpga_to_cpld_clk,
    input  logic            fpga_to_cpld_signal,
    input  logic            fpga_to_cpld_signal_2,
    input  logic            nubus_oe,
    input  logic            tmoen,
    input  logic            nubus_master_dir,
    input  logic [ID_W-1:0] id_n_5v,
    input  logic            reset_n_5v,
    input  logic            clk_n_5v,
    input  logic            clk2x_n_5v,
    output logic [ID_W-1:0] id_n_3v3,
    output logic            reset_n_3v3,
    output logic            clk_n_3v3,
    output logic            clk2x_n_3v3,
    input  logic            arb,
    input  logic [ID_W-1:0] arb_n_5v,
    output logic [ID_W-1:0] arb_o_n,
    output logic            grant,
    input  logic            tm0_n_5v,
    inout  wire             tm0_n_3v3,
    output logic            tm0_o_n,
    input  logic            tm1_n_5v,
    inout  wire             tm1_n_3v3,
    output logic            tm1_o_n,
    input  logic            tm2_n_5v,
    inout  wire             tm2_n_3v3,
    output logic            tm2_o_n,
    input  logic            start_n_5v,
    inout  wire             start_n_3v3,
    output logic            start_o_n,
    input  logic            ack_n_5v,
    inout  wire             ack_n_3v3,
    output logic            ack_o_n,
    output logic            tmx_oe_n,
    output logic            tm2_oe_n,
    output logic            start_oe_n,
    output logic            ack_oe_n,
    input  logic            rqst_n_3v3,
    input  logic            rqst_n_5v,
    output logic            rqst_o_n
);

    logic unused_ok;

    assign id_n_3v3    = id_n_5v;
    assign reset_n_3v3 = reset_n_5v;
    assign clk_n_3v3   = clk_n_5v;
    assign clk2x_n_3v3 = clk2x_n_5v;
    assign rqst_o_n    = rqst_n_3v3;

    // tmoen=1: FPGA drives TM/ACK onto the bus, 3.3 V side released.
    assign tmx_oe_n  = ~tmoen;
    assign ack_oe_n  = ~tmoen;
    assign tm0_o_n   = tm0_n_3v3;
    assign tm1_o_n   = tm1_n_3v3;
    assign ack_o_n   = ack_n_3v3;
    assign tm0_n_3v3 = tmoen ? 1'bz : tm0_n_5v;
    assign tm1_n_3v3 = tmoen ? 1'bz : tm1_n_5v;
    assign ack_n_3v3 = tmoen ? 1'bz : ack_n_5v;

    assign start_oe_n  = ~nubus_master_dir;
    assign start_o_n   = start_n_3v3;
    assign start_n_3v3 = nubus_master_dir ? 1'bz : start_n_5v;

`ifdef NUBUS_TM2_EN
    assign tm2_oe_n  = ~tmoen;
    assign tm2_o_n   = tm2_n_3v3;
    assign tm2_n_3v3 = tmoen ? 1'bz : tm2_n_5v;
    assign unused_ok = ^{fpga_to_cpld_signal_2, nubus_oe, rqst_n_5v};
`else
    assign tm2_oe_n  = 1'b1;
    assign tm2_o_n   = 1'b1;
    assign tm2_n_3v3 = 1'bz;
    assign unused_ok = ^{fpga_to_cpld_signal_2, nubus_oe, rqst_n_5v, tm2_n_5v};
`endif

    nubus_cpld_arb #(
        .ARB_SETTLE (ARB_SETTLE)
    ) u_arb (
        .fpga_to_cpld_clk    (fpga_to_cpld_clk),
        .fpga_to_cpld_signal (fpga_to_cpld_signal),
        .reset_n_5v          (reset_n_5v),
        .arb                 (arb),
        .id_n_5v             (id_n_5v),
        .arb_n_5v            (arb_n_5v),
        .arb_o_n             (arb_o_n),
        .grant               (grant)
    );

endmodule

// File: tb/tb_nubus_slot_cpld.sv
// Directed bench for nubus_slot_cpld: pass-through steering, arbitration timing, resets.
module tb_nubus_slot_cpld;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig2, nubus_oe, tmoen, master_dir;
    logic [3:0] id_n_5v;
    logic       reset_n_5v, clk_n_5v, clk2x_n_5v;
    logic [3:0] id_n_3v3;
    logic       reset_n_3v3, clk_n_3v3, clk2x_n_3v3;
    logic       arb;
    logic [3:0] arb_n_5v;
    logic [3:0] arb_o_n;
    logic       grant;
    logic       tm0_n_5v, tm1_n_5v, tm2_n_5v, start_n_5v, ack_n_5v;
    wire        tm0_n_3v3, tm1_n_3v3, tm2_n_3v3, start_n_3v3, ack_n_3v3;
    logic       tm0_o_n, tm1_o_n, tm2_o_n, start_o_n, ack_o_n;
    logic       tmx_oe_n, tm2_oe_n, start_oe_n, ack_oe_n;
    logic       rqst_n_3v3, rqst_n_5v, rqst_o_n;

    // Bench-side drivers for the 3.3 V bidirectional pins.
    logic       tb_tm_en, tb_start_en;
    logic       tb_tm0, tb_tm1, tb_tm2, tb_ack, tb_start;
    assign tm0_n_3v3   = tb_tm_en    ? tb_tm0   : 1'bz;
    assign tm1_n_3v3   = tb_tm_en    ? tb_tm1   : 1'bz;
    assign tm2_n_3v3   = tb_tm_en    ? tb_tm2   : 1'bz;
    assign ack_n_3v3   = tb_tm_en    ? tb_ack   : 1'bz;
    assign start_n_3v3 = tb_start_en ? tb_start : 1'bz;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    nubus_slot_cpld #(.ARB_SETTLE(2)) dut (
        .fpga_to_cpld_clk      (clk),
        .fpga_to_cpld_signal   (rst),
        .fpga_to_cpld_signal_2 (sig2),
        .nubus_oe              (nubus_oe),
        .tmoen                 (tmoen),
        .nubus_master_dir      (master_dir),
        .id_n_5v               (id_n_5v),
        .reset_n_5v            (reset_n_5v),
        .clk_n_5v              (clk_n_5v),
        .clk2x_n_5v            (clk2x_n_5v),
        .id_n_3v3              (id_n_3v3),
        .reset_n_3v3           (reset_n_3v3),
        .clk_n_3v3             (clk_n_3v3),
        .clk2x_n_3v3           (clk2x_n_3v3),
        .arb                   (arb),
        .arb_n_5v              (arb_n_5v),
        .arb_o_n               (arb_o_n),
        .grant                 (grant),
        .tm0_n_5v              (tm0_n_5v),
        .tm0_n_3v3             (tm0_n_3v3),
        .tm0_o_n               (tm0_o_n),
        .tm1_n_5v              (tm1_n_5v),
        .tm1_n_3v3             (tm1_n_3v3),
        .tm1_o_n               (tm1_o_n),
        .tm2_n_5v              (tm2_n_5v),
        .tm2_n_3v3             (tm2_n_3v3),
        .tm2_o_n               (tm2_o_n),
        .start_n_5v            (start_n_5v),
        .start_n_3v3           (start_n_3v3),
        .start_o_n             (start_o_n),
        .ack_n_5v              (ack_n_5v),
        .ack_n_3v3             (ack_n_3v3),
        .ack_o_n               (ack_o_n),
        .tmx_oe_n              (tmx_oe_n),
        .tm2_oe_n              (tm2_oe_n),
        .start_oe_n            (start_oe_n),
        .ack_oe_n              (ack_oe_n),
        .rqst_n_3v3            (rqst_n_3v3),
        .rqst_n_5v             (rqst_n_5v),
        .rqst_o_n              (rqst_o_n)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sig2 = 1'b0; nubus_oe = 1'b0; tmoen = 1'b0; master_dir = 1'b0;
        id_n_5v = 4'hF; reset_n_5v = 1'b1; clk_n_5v = 1'b0; clk2x_n_5v = 1'b0;
        arb = 1'b0; arb_n_5v = 4'hF;
        tm0_n_5v = 1'b1; tm1_n_5v = 1'b1; tm2_n_5v = 1'b1; start_n_5v = 1'b1; ack_n_5v = 1'b1;
        rqst_n_3v3 = 1'b1; rqst_n_5v = 1'b1;
        tb_tm_en = 1'b0; tb_start_en = 1'b0;
        tb_tm0 = 1'b1; tb_tm1 = 1'b1; tb_tm2 = 1'b1; tb_ack = 1'b1; tb_start = 1'b1;
        #3;
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_arb_o_n", 8'(arb_o_n), 8'h0F);
        chk("rst_id_pass", 8'(id_n_3v3), 8'h0F);
        #20 rst = 1'b0;
        tick();

        // Clock/reset pass-through: zero-cycle copies.
        clk_n_5v = 1'b1; clk2x_n_5v = 1'b1; #1;
        chk("clk_hi", 8'({clk_n_3v3, clk2x_n_3v3}), 8'h03);
        clk_n_5v = 1'b0; #1;
        chk("clk_lo", 8'({clk_n_3v3, clk2x_n_3v3}), 8'h01);
        chk("id_pass_F", 8'(id_n_3v3), 8'h0F);
        id_n_5v = 4'h3; #1;
        chk("id_pass_3", 8'(id_n_3v3), 8'h03);

        // Bus -> FPGA direction for TM/ACK.
        tmoen = 1'b0; tm1_n_5v = 1'b0; tm0_n_5v = 1'b1; ack_n_5v = 1'b0; #1;
        chk("tm10_in", 8'({tm1_n_3v3, tm0_n_3v3}), 8'h01);
        chk("tm_in_oe", 8'({tmx_oe_n, ack_oe_n}), 8'h03);
        chk("ack_in", 8'(ack_n_3v3), 8'h00);

        // FPGA -> bus direction for TM/ACK.
        tmoen = 1'b1; tb_tm_en = 1'b1; tb_ack = 1'b0; tb_tm0 = 1'b0; tb_tm1 = 1'b1; #1;
        chk("ack_out_oe", 8'(ack_oe_n), 8'h00);
        chk("ack_out", 8'(ack_o_n), 8'h00);
        chk("tm_out", 8'({tmx_oe_n, tm1_o_n, tm0_o_n}), 8'h02);
`ifdef NUBUS_TM2_EN
        tb_tm2 = 1'b0; #1;
        chk("tm2_oe", 8'({tm2_oe_n, tm2_o_n}), 8'h00);
`else
        tb_tm2 = 1'b0; #1;
        chk("tm2_oe", 8'({tm2_oe_n, tm2_o_n}), 8'h03);
`endif
        tb_tm_en = 1'b0; tmoen = 1'b0;

        // START direction.
        master_dir = 1'b1; tb_start_en = 1'b1; tb_start = 1'b0; #1;
        chk("start_out", 8'({start_oe_n, start_o_n}), 8'h00);
        tb_start_en = 1'b0; master_dir = 1'b0; start_n_5v = 1'b1; #1;
        chk("start_in", 8'({start_oe_n, start_n_3v3}), 8'h03);

        rqst_n_3v3 = 1'b0; #1;
        chk("rqst_lo", 8'(rqst_o_n), 8'h00);
        rqst_n_3v3 = 1'b1; #1;
        chk("rqst_hi", 8'(rqst_o_n), 8'h01);

        // ID 5 wins uncontested: grant on the 3rd edge after arb.
        id_n_5v = 4'hA; arb_n_5v = 4'hA; arb = 1'b1;
        tick();
        chk("arb_e1_grant", 8'(grant), 8'h00);
        chk("arb_e1_drive", 8'(arb_o_n), 8'h0A);
        tick();
        chk("arb_e2_grant", 8'(grant), 8'h00);
        tick();
        chk("arb_e3_grant", 8'(grant), 8'h01);

        // Bus-side reset while granted.
        reset_n_5v = 1'b0;
        tick();
        chk("rst5v_grant", 8'(grant), 8'h00);
        chk("rst5v_arb_o_n", 8'(arb_o_n), 8'h0F);
        reset_n_5v = 1'b1;
        tick(); tick(); tick();
        chk("rewin_grant", 8'(grant), 8'h01);

        // Async reset releases the ARB lines with no clock edge.
        @(negedge clk);
        rst = 1'b1; #1;
        chk("arst_grant", 8'(grant), 8'h00);
        chk("arst_arb_o_n", 8'(arb_o_n), 8'h0F);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rewin2_grant", 8'(grant), 8'h01);
        arb = 1'b0;
        tick();
        chk("drop_grant", 8'(grant), 8'h00);
        chk("drop_arb_o_n", 8'(arb_o_n), 8'h0F);

        // Higher-priority ID 9 on the bus: we back off entirely.
        arb = 1'b1; arb_n_5v = 4'h6;
        for (int i = 0; i < 5; i++) tick();
        chk("lose_arb_o_n", 8'(arb_o_n), 8'h0F);
        chk("lose_grant", 8'(grant), 8'h00);

        // A mismatching clock restarts the settle count.
        arb_n_5v = 4'hA; tick();
        arb_n_5v = 4'h6; tick();
        arb_n_5v = 4'hA; tick();
        chk("restart_g0", 8'(grant), 8'h00);
        tick();
        chk("restart_g1", 8'(grant), 8'h01);

        // ARB -> IDLE when the request drops before winning.
        arb = 1'b0; tick();
        arb = 1'b1; arb_n_5v = 4'h6; tick();
        arb = 1'b0; tick();
        chk("arb_abort", 8'({grant, arb_o_n}), 8'h0F);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
